// File: rtl/bsg_fsb_client_block_assembler.sv
// Collects sixteen 32-bit FSB payload words, addressed to this client and
// arriving in index order, into one 512-bit SHA-256 message block.
module bsg_fsb_client_block_assembler #(
  parameter int unsigned ring_width_p = 80,
  parameter int unsigned client_id_p  = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [511:0]            block_o,
  input  logic                    yumi_i,
  output logic                    err_o,
  output logic [7:0]              drop_count_o
);

  // Handshake: a packet moves when v_i && ready_o at a rising edge; ready_o
  // depends only on en_i and state. A block leaves when v_o && yumi_i.
  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  localparam logic [3:0] lp_client_id = client_id_p[3:0];

  state_e       r_state;
  state_e       w_state_nxt;
  logic [3:0]   r_exp_idx;
  logic [511:0] r_block;
  logic         r_err;
  logic [7:0]   r_drop_cnt;

  logic         w_xfer;
  logic         w_match;
  logic         w_idx_ok;
  logic         w_last;
  logic [3:0]   w_dest;
  logic [3:0]   w_idx;
  logic [31:0]  w_payload;
  logic [8:0]   w_word_lsb;
  logic         w_unused_data;

  assign w_dest        = data_i[ring_width_p-1 -: 4];
  assign w_idx         = data_i[35:32];
  assign w_payload     = data_i[31:0];
  // Bits between the index and dest fields carry no meaning for this client.
  assign w_unused_data = ^data_i;

  assign ready_o  = en_i && (r_state == COLLECT);
  assign w_xfer   = v_i && ready_o;
  assign w_match  = (w_dest == lp_client_id);
  assign w_idx_ok = (w_idx == r_exp_idx);
  assign w_last   = (r_exp_idx == 4'd15);

  // Word 0 sits in the MSBs, so word k starts at bit 32*(15-k).
  assign w_word_lsb = {~r_exp_idx, 5'd0};

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: begin
        if (w_xfer && w_match && w_idx_ok && w_last) begin
          w_state_nxt = FULL;
        end
      end
      FULL: begin
        if (yumi_i) begin
          w_state_nxt = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_exp_idx  <= 4'd0;
      r_block    <= '0;
      r_err      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (w_xfer) begin
      if (!w_match) begin
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end else if (w_idx_ok) begin
        r_block[w_word_lsb +: 32] <= w_payload;
        r_exp_idx                 <= r_exp_idx + 4'd1;
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  assign v_o          = (r_state == FULL);
  assign block_o      = r_block;
  assign err_o        = r_err;
  assign drop_count_o = r_drop_cnt;

endmodule
